// File: rtl/pio_poll_sequencer.sv
// Autonomous poller for a bank of read-only PIO slaves. Periodically sweeps every port,
// keeps shadow copies, flags per-port changes and exposes them over a small CSR slave.
module pio_poll_sequencer #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = 2,
  parameter int POLL_DIV  = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [SEL_W-1:0] pio_sel,
  output logic [1:0]       pio_address,
  input  logic [31:0]      pio_readdata,
  input  logic [2:0]       s_address,
  input  logic             s_read,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [31:0]      TIMER_RELOAD = 32'(POLL_DIV - 1);
  localparam logic [SEL_W-1:0] LAST_IDX     = SEL_W'(NUM_PORTS - 1);

  state_t                 state_r;
  state_t                 state_s;
  logic [31:0]            timer_r;
  logic [SEL_W-1:0]       idx_r;
  logic [1:0]             ctrl_r;
  logic [NUM_PORTS-1:0]   status_r;
  logic [NUM_PORTS-1:0]   valid_r;
  logic [SEL_W-1:0]       rdsel_r;
  logic [31:0]            shadow_r [NUM_PORTS];
  logic [31:0]            sweeps_r;
  logic [31:0]            s_readdata_r;

  logic                   start_s;
  logic                   capture_s;
  logic                   done_s;
  logic [NUM_PORTS-1:0]   set_mask_s;
  logic [NUM_PORTS-1:0]   clr_mask_s;
  logic [31:0]            rd_mux_s;
  logic                   unused_wdata_s;

  assign pio_sel        = idx_r;
  assign pio_address    = 2'b00;
  assign s_readdata     = s_readdata_r;
  assign irq            = ctrl_r[1] & (|status_r);
  assign unused_wdata_s = ^s_writedata;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and sweep control strobes
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    capture_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_r[0] && (timer_r == 32'd0)) begin
          state_s = ST_ISSUE;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_CAPTURE;
      ST_CAPTURE: begin
        capture_s = 1'b1;
        if (idx_r < LAST_IDX) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Sweep period timer: free-runs while a sweep is in flight so sweep starts stay periodic
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= TIMER_RELOAD;
    end else if ((state_r == ST_IDLE) && !ctrl_r[0]) begin
      timer_r <= TIMER_RELOAD;
    end else if (timer_r == 32'd0) begin
      timer_r <= TIMER_RELOAD;
    end else begin
      timer_r <= timer_r - 32'd1;
    end
  end

  // Port index; parks on the last port between sweeps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r <= {SEL_W{1'b0}};
    end else if (start_s) begin
      idx_r <= {SEL_W{1'b0}};
    end else if (capture_s && (idx_r < LAST_IDX)) begin
      idx_r <= idx_r + {{(SEL_W-1){1'b0}}, 1'b1};
    end
  end

  // Change detection: a port's first capture only establishes its baseline
  always_comb begin
    set_mask_s = {NUM_PORTS{1'b0}};
    if (capture_s && valid_r[idx_r] && (pio_readdata != shadow_r[idx_r])) begin
      set_mask_s[idx_r] = 1'b1;
    end else begin
      set_mask_s = {NUM_PORTS{1'b0}};
    end
  end

  // Write-1-to-clear mask for STATUS
  always_comb begin
    clr_mask_s = {NUM_PORTS{1'b0}};
    if (s_write && (s_address == 3'd1)) begin
      clr_mask_s = s_writedata[NUM_PORTS-1:0];
    end else begin
      clr_mask_s = {NUM_PORTS{1'b0}};
    end
  end

  // Shadow copies, baseline flags, STATUS (hardware set beats software clear) and sweep count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        shadow_r[i] <= 32'd0;
      end
      valid_r  <= {NUM_PORTS{1'b0}};
      status_r <= {NUM_PORTS{1'b0}};
      sweeps_r <= 32'd0;
    end else begin
      if (capture_s) begin
        shadow_r[idx_r] <= pio_readdata;
        valid_r[idx_r]  <= 1'b1;
      end
      status_r <= (status_r & ~clr_mask_s) | set_mask_s;
      if (done_s) begin
        sweeps_r <= sweeps_r + 32'd1;
      end
    end
  end

  // Writable CSRs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r  <= 2'b00;
      rdsel_r <= {SEL_W{1'b0}};
    end else if (s_write) begin
      if (s_address == 3'd0) begin
        ctrl_r <= s_writedata[1:0];
      end
      if (s_address == 3'd2) begin
        rdsel_r <= s_writedata[SEL_W-1:0];
      end
    end
  end

  // CSR read mux
  always_comb begin
    rd_mux_s = 32'd0;
    case (s_address)
      3'd0: rd_mux_s = {30'd0, ctrl_r};
      3'd1: rd_mux_s = 32'(status_r);
      3'd2: rd_mux_s = 32'(rdsel_r);
      3'd3: begin
        if (int'(rdsel_r) < NUM_PORTS) begin
          rd_mux_s = shadow_r[rdsel_r];
        end else begin
          rd_mux_s = 32'd0;
        end
      end
      3'd4:    rd_mux_s = sweeps_r;
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata_r <= 32'd0;
    end else if (s_read) begin
      s_readdata_r <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_pio_poll_sequencer.sv
// Directed bench for pio_poll_sequencer: CSR reads go through an expected-value queue
// checked by a monitor; timing-sensitive signals are checked inline.
module tb_pio_poll_sequencer;
  localparam int NP = 4;
  localparam int SW = 2;
  localparam int PD = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [SW-1:0] pio_sel;
  logic [1:0]    pio_address;
  logic [31:0]   pio_readdata = 32'd0;
  logic [2:0]    s_address = 3'd0;
  logic          s_read = 1'b0;
  logic          s_write = 1'b0;
  logic [31:0]   s_writedata = 32'd0;
  logic [31:0]   s_readdata;
  logic          irq;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] port_val [NP];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rd_flag = 1'b0;

  pio_poll_sequencer #(.NUM_PORTS(NP), .SEL_W(SW), .POLL_DIV(PD)) dut (
    .clk(clk), .reset_n(reset_n), .pio_sel(pio_sel), .pio_address(pio_address),
    .pio_readdata(pio_readdata), .s_address(s_address), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // PIO bank model: registered readdata of the selected port
  always @(posedge clk) pio_readdata <= port_val[pio_sel];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_flag <= s_read & reset_n;

  // Scoreboard monitor: read data is valid in the cycle after the read strobe
  always @(negedge clk) begin
    if (rd_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %h", s_readdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (s_readdata !== mon_e.val) begin
          errors++;
          $display("FAIL rd_%s got %h exp %h", mon_e.name, s_readdata, mon_e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    if (cyc > c) begin
      checks++;
      errors++;
      $display("FAIL sched got %0d exp %0d", cyc, c);
    end
    while (cyc < c) step(1);
  endtask

  task automatic csr_write(input logic [2:0] addr, input logic [31:0] data);
    s_address   = addr;
    s_writedata = data;
    s_write     = 1'b1;
    step(1);
    s_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] addr, input string name, input logic [31:0] exp);
    exp_t e;
    e.name    = name;
    e.val     = exp;
    exp_q.push_back(e);
    s_address = addr;
    s_read    = 1'b1;
    step(1);
    s_read    = 1'b0;
  endtask

  task automatic sel_seq(input int s, input string tag);
    wait_cyc(s);
    for (int i = 0; i < 2 * NP; i++) begin
      check($sformatf("%s_sel%0d", tag, i), 32'(pio_sel), 32'(i / 2));
      step(1);
    end
  endtask

  int   s;
  logic sel_changed;
  logic [SW-1:0] sel0;

  initial begin
    port_val[0] = 32'h11; port_val[1] = 32'h22; port_val[2] = 32'h33; port_val[3] = 32'h44;
    step(3);
    check("rst_pio_sel", 32'(pio_sel), 32'd0);
    check("rst_pio_address", 32'(pio_address), 32'd0);
    check("rst_s_readdata", s_readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    step(1);
    csr_read(3'd0, "rst_ctrl", 32'd0);
    csr_read(3'd1, "rst_status", 32'd0);
    csr_read(3'd4, "rst_sweeps", 32'd0);
    csr_read(3'd3, "rst_shadow", 32'd0);

    // Baseline sweep
    s = cyc + 1 + PD;
    csr_write(3'd0, 32'd1);
    sel_seq(s, "t1");
    wait_cyc(s + 10);
    csr_write(3'd2, 32'd2);
    csr_read(3'd3, "t1_shadow2", 32'h33);
    csr_read(3'd1, "t1_status", 32'd0);
    csr_read(3'd4, "t1_sweeps", 32'd1);
    check("t1_irq", 32'(irq), 32'd0);

    // Change on port 1 flags and raises irq; W1C clears
    port_val[1] = 32'hABCD;
    csr_write(3'd0, 32'd3);
    s = s + PD;
    sel_seq(s, "t2");
    wait_cyc(s + 10);
    check("t2_irq", 32'(irq), 32'd1);
    csr_read(3'd1, "t2_status", 32'h2);
    csr_write(3'd1, 32'h2);
    check("t2_irq_clr", 32'(irq), 32'd0);
    csr_read(3'd1, "t2_status_clr", 32'd0);

    // Port 3 toggles; W1C in its capture cycle loses to the hardware set
    port_val[3] = 32'h55;
    s = s + PD;
    wait_cyc(s + 10);
    check("t3_irq_a", 32'(irq), 32'd1);
    csr_read(3'd1, "t3_status_a", 32'h8);
    port_val[3] = 32'h44;
    s = s + PD;
    wait_cyc(s + 7);
    csr_write(3'd1, 32'h8);
    check("t3_irq_setwins", 32'(irq), 32'd1);
    csr_read(3'd1, "t3_status_b", 32'h8);
    csr_write(3'd2, 32'd3);
    port_val[3] = 32'h66;
    s = s + PD;
    wait_cyc(s + 7);
    csr_read(3'd3, "t3_shadow_pre", 32'h44);
    csr_read(3'd3, "t3_shadow_post", 32'h66);

    // Disable during ISSUE of port 1: sweep still completes, then stays idle
    port_val[1] = 32'h1111; port_val[2] = 32'h2222; port_val[3] = 32'h7777;
    s = s + PD;
    wait_cyc(s + 2);
    csr_write(3'd0, 32'd2);
    wait_cyc(s + 10);
    csr_read(3'd1, "t4_status", 32'hE);
    csr_read(3'd4, "t4_sweeps", 32'd6);
    csr_read(3'd3, "t4_shadow3", 32'h7777);
    csr_write(3'd2, 32'd1);
    csr_read(3'd3, "t4_shadow1", 32'h1111);
    csr_write(3'd2, 32'd2);
    csr_read(3'd3, "t4_shadow2", 32'h2222);
    check("t4_irq", 32'(irq), 32'd1);
    sel0 = pio_sel;
    sel_changed = 1'b0;
    for (int i = 0; i < 3 * PD; i++) begin
      step(1);
      if (pio_sel != sel0) sel_changed = 1'b1;
    end
    check("t4_sel_idle", 32'(sel0), 32'd3);
    check("t4_sel_quiet", 32'(sel_changed), 32'd0);
    csr_read(3'd4, "t4_sweeps_after", 32'd6);

    // Sweep counter wrap, unmapped reads, read-only writes
    csr_write(3'd1, 32'hF);
    check("t5_irq_clr", 32'(irq), 32'd0);
    csr_read(3'd1, "t5_status_clr", 32'd0);
    force dut.sweeps_r = 32'hFFFF_FFFF;
    step(1);
    release dut.sweeps_r;
    csr_read(3'd4, "t5_sweeps_pre", 32'hFFFF_FFFF);
    s = cyc + 1 + PD;
    csr_write(3'd0, 32'd1);
    wait_cyc(s + 10);
    csr_read(3'd4, "t5_sweeps_wrap", 32'd0);
    csr_write(3'd0, 32'd0);
    csr_read(3'd6, "t5_addr6", 32'd0);
    csr_read(3'd5, "t5_addr5", 32'd0);
    csr_read(3'd7, "t5_addr7", 32'd0);
    csr_write(3'd2, 32'd0);
    csr_write(3'd3, 32'hDEAD_BEEF);
    csr_read(3'd3, "t5_shadow_ro", 32'h11);
    csr_write(3'd4, 32'h1234);
    csr_read(3'd4, "t5_sweeps_ro", 32'd0);

    // Reset mid-capture, then re-baseline
    port_val[0] = 32'h99;
    s = cyc + 1 + PD;
    csr_write(3'd0, 32'd3);
    wait_cyc(s + 10);
    check("t6_irq_pre", 32'(irq), 32'd1);
    csr_read(3'd1, "t6_status_pre", 32'h1);
    s = s + PD;
    wait_cyc(s + 3);
    reset_n = 1'b0;
    #1;
    check("t6_rst_pio_sel", 32'(pio_sel), 32'd0);
    check("t6_rst_pio_address", 32'(pio_address), 32'd0);
    check("t6_rst_s_readdata", s_readdata, 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    csr_read(3'd0, "t6_ctrl", 32'd0);
    csr_read(3'd1, "t6_status", 32'd0);
    csr_read(3'd4, "t6_sweeps", 32'd0);
    csr_read(3'd3, "t6_shadow", 32'd0);
    port_val[0] = 32'h5A;
    s = cyc + 1 + PD;
    csr_write(3'd0, 32'd3);
    wait_cyc(s + 10);
    check("t6_irq_rebase", 32'(irq), 32'd0);
    csr_read(3'd1, "t6_status_rebase", 32'd0);
    csr_read(3'd4, "t6_sweeps_rebase", 32'd1);
    csr_read(3'd3, "t6_shadow_rebase", 32'h5A);
    csr_write(3'd0, 32'd0);
    step(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
